// File: rtl/la_ioring_seq.sv
// Staged io-ring power sequencer: raises ring bits one at a time, lowers them in reverse.
// Optional status readback and timeout fault are enabled by defining LA_IORING_SEQ_STATUS_EN.
module la_ioring_seq #(
  parameter int RINGW   = 8,
  parameter int STEPCYC = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [RINGW-1:0] ring_in,
  output logic [RINGW-1:0] ring_out,
  output logic             ready,
  output logic             busy,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_UP,
    ST_ON,
    ST_DOWN,
    ST_FAULT
  } state_t;

  localparam int              IDXW      = (RINGW > 1) ? $clog2(RINGW) : 1;
  localparam logic [15:0]     STEP_LAST = 16'(STEPCYC - 1);
  localparam logic [IDXW-1:0] IDX_TOP   = IDXW'(RINGW - 1);

  state_t           state_q, state_d;
  logic [RINGW-1:0] ring_q, ring_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             step_ok;
  logic             timed_out;

`ifdef LA_IORING_SEQ_STATUS_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  // A step may be late (waiting on the pad status) but never early.
  assign step_ok   = (cnt_q >= STEP_LAST) && ring_in[idx_q];
  assign timed_out = (cnt_q == TIMEOUT_LAST) && !ring_in[idx_q];
`else
  logic unused_ring_in;

  assign unused_ring_in = ^ring_in;
  assign step_ok        = (cnt_q == STEP_LAST);
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    ring_d  = ring_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_UP;
          ring_d  = RINGW'(1);
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_UP, ST_ON: begin
        if (!en) begin
          // Drop the topmost set bit now; bit 0 going low means the ring is already off.
          ring_d[idx_q] = 1'b0;
          cnt_d         = '0;
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_DOWN;
            idx_d   = idx_q - IDXW'(1);
          end
        end else if (state_q == ST_UP) begin
          if (step_ok) begin
            cnt_d = '0;
            if (idx_q == IDX_TOP) begin
              state_d = ST_ON;
            end else begin
              idx_d         = idx_q + IDXW'(1);
              ring_d[idx_d] = 1'b1;
            end
          end else if (timed_out) begin
            state_d = ST_FAULT;
            ring_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_DOWN: begin
        // Requests are ignored here: the power-down always runs to completion.
        if (cnt_q == STEP_LAST) begin
          ring_d[idx_q] = 1'b0;
          cnt_d         = '0;
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_FAULT: begin
        ring_d = '0;
      end

      default: begin
        state_d = ST_OFF;
        ring_d  = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_OFF;
      ring_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ring_out = ring_q;
  assign ready    = (state_q == ST_ON);
  assign busy     = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_la_ioring_seq.sv
// Self-checking bench for la_ioring_seq: directed timeline checks plus randomized
// traffic compared each cycle against a level/timer reference model.
module tb_la_ioring_seq;

  localparam int RINGW   = 4;
  localparam int STEPCYC = 3;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [RINGW-1:0] ring_in;
  logic [RINGW-1:0] ring_out;
  logic             ready;
  logic             busy;
  logic             fault;

  always #5 clk = ~clk;

  la_ioring_seq #(
    .RINGW  (RINGW),
    .STEPCYC(STEPCYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .ring_in (ring_in),
    .ring_out(ring_out),
    .ready   (ready),
    .busy    (busy),
    .fault   (fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: number of raised bits, time since the last change, and
  // whether a sequence is in flight (and in which direction).
  int m_lvl = 0;
  int m_tmr = 0;
  bit m_act = 0;
  bit m_up  = 0;
  bit m_flt = 0;

  function automatic bit status_ok(input int b);
`ifdef LA_IORING_SEQ_STATUS_EN
    return ring_in[b];
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit status_en();
`ifdef LA_IORING_SEQ_STATUS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_lvl = 0; m_tmr = 0; m_act = 0; m_up = 0; m_flt = 0;
    end else if (m_flt) begin
      m_lvl = 0;
    end else if (!m_act) begin
      if (m_lvl == 0 && en) begin
        m_lvl = 1; m_act = 1; m_up = 1; m_tmr = 0;
      end else if (m_lvl == RINGW && !en) begin
        m_lvl--; m_tmr = 0; m_up = 0; m_act = (m_lvl > 0);
      end
    end else if (m_up) begin
      if (!en) begin
        m_lvl--; m_tmr = 0; m_up = 0; m_act = (m_lvl > 0);
      end else if (m_tmr >= STEPCYC - 1 && status_ok(m_lvl - 1)) begin
        m_tmr = 0;
        if (m_lvl == RINGW) m_act = 0;
        else m_lvl++;
      end else if (status_en() && m_tmr == TIMEOUT - 1) begin
        m_flt = 1; m_lvl = 0; m_act = 0; m_tmr = 0;
      end else begin
        m_tmr++;
      end
    end else begin
      if (m_tmr == STEPCYC - 1) begin
        m_lvl--; m_tmr = 0;
        if (m_lvl == 0) m_act = 0;
      end else begin
        m_tmr++;
      end
    end
  endtask

  task automatic check_model();
    logic [RINGW-1:0] exp_ring;
    exp_ring = RINGW'((1 << m_lvl) - 1);
    check("ring_out", 32'(ring_out), 32'(exp_ring));
    check("ready", 32'(ready), 32'(!m_act && !m_flt && m_lvl == RINGW));
    check("busy", 32'(busy), 32'(m_act));
    check("fault", 32'(fault), 32'(m_flt));
  endtask

  // Inputs change only between negedge and the next posedge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [RINGW-1:0] up_seq [RINGW] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    reset = 1'b1; en = 1'b0; ring_in = '1;
    ticks(2);
    check("rst_ring", 32'(ring_out), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // Power-up timeline.
    reset = 1'b0; en = 1'b1;
    tick();
    check("up_e1", 32'(ring_out), 32'(up_seq[0]));
    check("up_busy", 32'(busy), 32'h1);
    for (int k = 1; k < RINGW; k++) begin
      ticks(STEPCYC);
      check("up_step", 32'(ring_out), 32'(up_seq[k]));
      check("up_notready", 32'(ready), 32'h0);
    end
    ticks(STEPCYC);
    check("on_ready", 32'(ready), 32'h1);
    check("on_busy", 32'(busy), 32'h0);

    // Power-down from ON.
    en = 1'b0;
    tick();
    check("dn_first", 32'(ring_out), 32'h7);
    check("dn_ready", 32'(ready), 32'h0);
    ticks(STEPCYC);     check("dn_2", 32'(ring_out), 32'h3);
    ticks(STEPCYC);     check("dn_1", 32'(ring_out), 32'h1);
    ticks(STEPCYC);     check("dn_0", 32'(ring_out), 32'h0);
    check("dn_busy", 32'(busy), 32'h0);

    // Abort mid-step during power-up.
    en = 1'b1;
    ticks(1 + STEPCYC + 1);
    check("ab_mid", 32'(ring_out), 32'h3);
    en = 1'b0;
    tick();             check("ab_first", 32'(ring_out), 32'h1);
    ticks(STEPCYC);     check("ab_off", 32'(ring_out), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);

    // Reset mid-UP, then automatic restart with en still high.
    en = 1'b1;
    ticks(1 + 2 * STEPCYC + 1);
    check("rs_mid", 32'(ring_out), 32'h7);
    reset = 1'b1;
    tick();
    check("rs_ring", 32'(ring_out), 32'h0);
    check("rs_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();             check("rs_restart", 32'(ring_out), 32'h1);

    // Re-request during DOWN completes to OFF before restarting.
    ticks(RINGW * STEPCYC);
    check("rq_on", 32'(ready), 32'h1);
    en = 1'b0;
    tick();
    ticks(STEPCYC);     check("rq_3", 32'(ring_out), 32'h3);
    en = 1'b1;
    ticks(STEPCYC);     check("rq_1", 32'(ring_out), 32'h1);
    ticks(STEPCYC);     check("rq_0", 32'(ring_out), 32'h0);
    check("rq_idle", 32'(busy), 32'h0);
    tick();             check("rq_up", 32'(ring_out), 32'h1);
    ticks(RINGW * STEPCYC);
    check("rq_ready", 32'(ready), 32'h1);

`ifdef LA_IORING_SEQ_STATUS_EN
    // Status never arrives: fault after TIMEOUT edges, sticky until reset.
    reset = 1'b1; en = 1'b0; ring_in = '0;
    tick();
    reset = 1'b0; en = 1'b1;
    tick();             check("to_e1", 32'(ring_out), 32'h1);
    ticks(TIMEOUT - 1); check("to_wait", 32'(fault), 32'h0);
    tick();
    check("to_fault", 32'(fault), 32'h1);
    check("to_ring", 32'(ring_out), 32'h0);
    en = 1'b0; ticks(3);
    en = 1'b1; ticks(3);
    check("to_sticky", 32'(fault), 32'h1);
    reset = 1'b1;
    tick();             check("to_clear", 32'(fault), 32'h0);
    reset = 1'b0; ring_in = '1;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      reset = ($urandom_range(0, 299) == 0);
`ifdef LA_IORING_SEQ_STATUS_EN
      for (int b = 0; b < RINGW; b++) ring_in[b] = ($urandom_range(0, 3) != 0);
`else
      ring_in = RINGW'($urandom);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
